sim_run_supervisor: RTL and testbench
=====================================

# sim_run_supervisor

Host-side run controller for the simulation control path. It accepts a batch command, then drives the control path's active-low reset and `start` for each run. It watches `steady_state` and `iteration_number` until the network settles or an iteration limit is hit, and returns one result record per run over a valid/ready handshake. It sits between the host interface and the simulation control path, on the opposite side of its `start` / `steady_state` / `iteration_number` interface.

## Interface
Parameters:
- `ITER_W`, 10: width of the iteration counter; must match the control path.
- `RUN_W`, 8: width of the run count and the run index.
- `STEADY_HOLD`, 4: number of consecutive `sim_steady` cycles that qualify as settled; legal range 1..15.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: batch command valid.
- `cmd_ready` output 1: block can accept a command.
- `cmd_runs` input RUN_W: number of runs in the batch.
- `cmd_limit` input ITER_W: per-run iteration limit; 0 means 2^ITER_W−1.
- `sim_rst_n` output 1: reset to the control path, active-low.
- `sim_start` output 1: start pulse to the control path.
- `sim_steady` input 1: control path `steady_state` output.
- `sim_iter` input ITER_W: control path `iteration_number` output.
- `res_valid` output 1: result record valid.
- `res_ready` input 1: host accepts the result record.
- `res_run_idx` output RUN_W: index of the run, 0-based.
- `res_iter` output ITER_W: iteration count captured for the run.
- `res_timeout` output 1: 1 means the limit was hit, 0 means the run settled.
- `busy` output 1: high whenever the block is not in IDLE.
- `done` output 1: one-cycle pulse when a batch completes.

## Operation
State machine has five states: IDLE, SIMRST, START, RUN, REPORT.

- IDLE
  - `cmd_ready`=1; `sim_rst_n`=0, so the control path is held in reset.
  - On `cmd_valid`: latch `cmd_runs` and `cmd_limit`, clear the run index.
  - If `cmd_runs`==0: pulse `done` next cycle and stay in IDLE. Otherwise go to SIMRST.
- SIMRST
  - `sim_rst_n`=0 for exactly 2 cycles, then go to START.
- START
  - `sim_rst_n`=1, `sim_start`=1 for 1 cycle, then go to RUN.
- RUN
  - `sim_rst_n`=1, `sim_start`=0.
  - Hold counter: increments while `sim_steady`=1, clears to 0 when `sim_steady`=0, saturates at STEADY_HOLD.
  - Settled: the counter reaches STEADY_HOLD. Capture `res_iter`=`sim_iter` of that cycle and `res_timeout`=0.
  - Timeout: `sim_iter` ≥ effective limit. Capture `res_iter`=effective limit and `res_timeout`=1.
  - If settled and timeout occur in the same cycle, settled wins.
  - Go to REPORT.
- REPORT
  - `res_valid`=1; all `res_*` fields stay stable until `res_ready`.
  - `sim_rst_n`=0, freezing the control path.
  - On handshake: increment the run index. If run index+1 < runs, go to SIMRST. Otherwise pulse `done` and go to IDLE.
- `cmd_valid` is ignored outside IDLE.
- Width rules: all comparisons are unsigned at ITER_W. The run index never exceeds `cmd_runs`−1.

## Timing
- Reset values while `rst`=1: state=IDLE, `cmd_ready`=0, `sim_rst_n`=0, `sim_start`=0, `res_valid`=0, `res_*`=0, `busy`=0, `done`=0, hold counter=0.
- First cycle after `rst` deasserts: `cmd_ready`=1.
- Reset mid-run: takes effect on the next edge, with no result emitted and no `done`.
- Command handshake at edge N:
  - `busy`=1 from N+1.
  - `sim_rst_n` low on N+1 and N+2.
  - `sim_start` high on N+3.
  - The control path enters simulation on N+4.
- The settle or timeout decision is registered, so `res_valid` rises 1 cycle after the qualifying sample.
- Back-to-back runs: from the result handshake at edge M, the next `sim_start` is at M+3.
- `done` is high for exactly 1 cycle: it coincides with the first IDLE cycle, where `cmd_ready`=1.

## Structure
- Package `sim_sup_pkg` holds:
  - the state enum;
  - default ITER_W and RUN_W localparams;
  - a packed result struct {run_idx, iter, timeout}.
- Sub-module `steady_filter`: hold counter plus the settled flag. Parameterized by STEADY_HOLD; clear input is driven high in all states except RUN.

## Test plan
- **Settle:** runs=1, limit=100; `sim_steady` rises at `sim_iter`=20 and holds. Expect `res_iter`=23, timeout=0, run_idx=0, and `done` one cycle after the handshake.
- **Timeout:** runs=1, limit=50; `sim_steady` never asserts. Expect `res_iter`=50, timeout=1.
- **Glitchy steady:** `sim_steady` pattern 1,1,1,0,1,1,1,1 with STEADY_HOLD=4. Expect capture only on the 8th cycle.
- **Batch with backpressure:** runs=3; `res_ready` held low for 5 cycles per record. Expect run_idx 0,1,2, fields stable while stalled, each next `sim_start` 3 cycles after its handshake.
- **Edge commands and limits:**
  - runs=0: `done` next cycle and no `sim_start`.
  - limit=0: timeout at `sim_iter`=1023.
  - settle and timeout in the same cycle: settled wins.
- **Reset mid-RUN:** at the next edge, all outputs return to their reset values, no `res_valid`, and `cmd_ready`=1 after `rst` deasserts.

Source files
------------

// File: rtl/sim_run_supervisor_pkg.sv
// sim_sup_pkg: shared types for the simulation run supervisor.
//   state_t  - supervisor FSM states
//   result_t - one result record {run_idx, iter, timeout} at the default widths
//   DEF_ITER_W / DEF_RUN_W - default iteration counter and run index widths
package sim_sup_pkg;

    localparam int DEF_ITER_W = 10;
    localparam int DEF_RUN_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SIMRST = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_REPORT = 3'd4
    } state_t;

    typedef struct packed {
        logic [DEF_RUN_W-1:0]  run_idx;
        logic [DEF_ITER_W-1:0] iter;
        logic                  timeout;
    } result_t;

endpackage

// File: rtl/sim_run_supervisor_if.sv
// sim_run_supervisor_if: host-side command and result channels.
//   cmd_*  - batch command (runs, iteration limit), host -> supervisor
//   res_*  - per-run result record, supervisor -> host
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high. The sender holds valid and its payload stable until that edge and
// never withdraws valid; the receiver may drive ready independently of valid.
// Modports: master = host side, slave = supervisor side.
interface sim_run_supervisor_if #(
    parameter int ITER_W = 10,
    parameter int RUN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [RUN_W-1:0]  cmd_runs;
    logic [ITER_W-1:0] cmd_limit;

    logic              res_valid;
    logic              res_ready;
    logic [RUN_W-1:0]  res_run_idx;
    logic [ITER_W-1:0] res_iter;
    logic              res_timeout;

    modport master (
        output cmd_valid, cmd_runs, cmd_limit, res_ready,
        input  cmd_ready, res_valid, res_run_idx, res_iter, res_timeout
    );

    modport slave (
        input  cmd_valid, cmd_runs, cmd_limit, res_ready,
        output cmd_ready, res_valid, res_run_idx, res_iter, res_timeout
    );
endinterface

// File: rtl/sim_run_supervisor_steady.sv
// steady_filter: counts consecutive cycles of steady=1 and flags the cycle in
// which the count reaches STEADY_HOLD (legal 1..15).
//   clk, rst - clock, synchronous active-high reset
//   clear    - forces the counter to 0 and masks settled (high outside RUN)
//   steady   - control path steady_state
//   settled  - this cycle's sample brings the count to STEADY_HOLD
module steady_filter #(
    parameter int STEADY_HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic steady,
    output logic settled
);
    localparam logic [3:0] HOLD    = 4'(STEADY_HOLD);
    localparam logic [3:0] HOLD_M1 = 4'(STEADY_HOLD - 1);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 4'd0;
        end else if (!steady) begin
            count <= 4'd0;
        end else if (count != HOLD) begin
            count <= count + 4'd1;
        end
    end

    // Settled is judged on the value the counter is about to take, so the
    // capture happens on the very sample that completes the hold window.
    assign settled = !clear && steady && (count >= HOLD_M1);
endmodule

// File: rtl/sim_run_supervisor.sv
// sim_run_supervisor: runs a batch of simulations on the control path.
//   clk, rst    - clock, synchronous active-high reset
//   host        - command / result channels (slave side of the interface)
//   sim_rst_n   - active-low reset to the control path
//   sim_start   - one-cycle start pulse to the control path
//   sim_steady  - control path steady_state
//   sim_iter    - control path iteration_number
//   busy        - high whenever the FSM is not in IDLE
//   done        - one-cycle pulse on the first IDLE cycle after a batch
//   dbg_state   - current FSM state
module sim_run_supervisor
    import sim_sup_pkg::*;
#(
    parameter int ITER_W      = DEF_ITER_W,
    parameter int RUN_W       = DEF_RUN_W,
    parameter int STEADY_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    sim_run_supervisor_if.slave host,
    output logic              sim_rst_n,
    output logic              sim_start,
    input  logic              sim_steady,
    input  logic [ITER_W-1:0] sim_iter,
    output logic              busy,
    output logic              done,
    output state_t            dbg_state
);
    state_t            state;
    logic              cmd_ready_q;
    logic              res_valid_q;
    logic [RUN_W-1:0]  res_run_idx_q;
    logic [ITER_W-1:0] res_iter_q;
    logic              res_timeout_q;
    logic [RUN_W-1:0]  runs;
    logic [ITER_W-1:0] limit;
    logic [RUN_W-1:0]  run_idx;
    logic [RUN_W:0]    run_next;
    logic [ITER_W-1:0] cmd_limit_eff;
    logic              rst_cnt;
    logic              settled;

    // A limit of 0 selects the largest representable iteration count.
    assign cmd_limit_eff = (host.cmd_limit == '0) ? '1 : host.cmd_limit;
    // One bit wider so the last-run test cannot wrap.
    assign run_next      = {1'b0, run_idx} + {{RUN_W{1'b0}}, 1'b1};

    steady_filter #(
        .STEADY_HOLD(STEADY_HOLD)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_RUN),
        .steady  (sim_steady),
        .settled (settled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cmd_ready_q   <= 1'b0;
            sim_rst_n     <= 1'b0;
            sim_start     <= 1'b0;
            res_valid_q   <= 1'b0;
            res_run_idx_q <= '0;
            res_iter_q    <= '0;
            res_timeout_q <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            runs          <= '0;
            limit         <= '0;
            run_idx       <= '0;
            rst_cnt       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    sim_rst_n   <= 1'b0;
                    sim_start   <= 1'b0;
                    busy        <= 1'b0;
                    if (host.cmd_valid && cmd_ready_q) begin
                        runs    <= host.cmd_runs;
                        limit   <= cmd_limit_eff;
                        run_idx <= '0;
                        if (host.cmd_runs == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= ST_SIMRST;
                            cmd_ready_q <= 1'b0;
                            busy        <= 1'b1;
                            rst_cnt     <= 1'b0;
                        end
                    end
                end
                ST_SIMRST: begin
                    sim_rst_n <= 1'b0;
                    if (rst_cnt) begin
                        state     <= ST_START;
                        sim_rst_n <= 1'b1;
                        sim_start <= 1'b1;
                    end else begin
                        rst_cnt <= 1'b1;
                    end
                end
                ST_START: begin
                    sim_start <= 1'b0;
                    state     <= ST_RUN;
                end
                ST_RUN: begin
                    // Settled is tested first so it wins a tie with the limit.
                    if (settled || (sim_iter >= limit)) begin
                        state         <= ST_REPORT;
                        res_valid_q   <= 1'b1;
                        res_run_idx_q <= run_idx;
                        res_iter_q    <= settled ? sim_iter : limit;
                        res_timeout_q <= !settled;
                        sim_rst_n     <= 1'b0;
                    end
                end
                ST_REPORT: begin
                    if (host.res_ready) begin
                        res_valid_q <= 1'b0;
                        if (run_next < {1'b0, runs}) begin
                            run_idx <= run_next[RUN_W-1:0];
                            state   <= ST_SIMRST;
                            rst_cnt <= 1'b0;
                        end else begin
                            state       <= ST_IDLE;
                            done        <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign host.cmd_ready   = cmd_ready_q;
    assign host.res_valid   = res_valid_q;
    assign host.res_run_idx = res_run_idx_q;
    assign host.res_iter    = res_iter_q;
    assign host.res_timeout = res_timeout_q;
    assign dbg_state        = state;
endmodule

// File: tb/tb_sim_run_supervisor.sv
// Testbench for sim_run_supervisor: directed scenarios with hand-computed
// expectations. Inputs change 1 ns after the rising edge; outputs are read
// at the same point, after the edge has settled.
module tb_sim_run_supervisor;
    import sim_sup_pkg::*;

    localparam int ITER_W = 10;
    localparam int RUN_W  = 8;

    logic              clk;
    logic              rst;
    logic              sim_rst_n;
    logic              sim_start;
    logic              sim_steady;
    logic [ITER_W-1:0] sim_iter;
    logic              busy;
    logic              done;
    state_t            dbg_state;

    int checks;
    int errors;

    sim_run_supervisor_if #(.ITER_W(ITER_W), .RUN_W(RUN_W)) hif ();

    sim_run_supervisor #(
        .ITER_W(ITER_W), .RUN_W(RUN_W), .STEADY_HOLD(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (hif),
        .sim_rst_n  (sim_rst_n),
        .sim_start  (sim_start),
        .sim_steady (sim_steady),
        .sim_iter   (sim_iter),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int runs, input int limit);
        for (int i = 0; i < 10 && !hif.cmd_ready; i++) tick();
        hif.cmd_valid = 1'b1;
        hif.cmd_runs  = RUN_W'(runs);
        hif.cmd_limit = ITER_W'(limit);
        tick();
        hif.cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sim_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called in the START cycle. Sample c drives sim_iter=c; sim_steady comes
    // from pat for the first pat_len samples, then is (c >= steady_from).
    task automatic drive_run(input logic [15:0] pat, input int pat_len,
                             input int steady_from, input int max_c,
                             output bit got, output int last_c);
        got    = 1'b0;
        last_c = -1;
        sim_iter   = '0;
        sim_steady = 1'b0;
        tick();
        for (int c = 0; c <= max_c; c++) begin
            sim_iter   = ITER_W'(c);
            sim_steady = (c < pat_len) ? pat[c] : (c >= steady_from);
            tick();
            if (hif.res_valid) begin
                got    = 1'b1;
                last_c = c;
                break;
            end
        end
        sim_steady = 1'b0;
    endtask

    task automatic ack_result();
        hif.res_ready = 1'b1;
        tick();
        hif.res_ready = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        checks++; if ({hif.cmd_ready, sim_rst_n, sim_start, hif.res_valid, busy, done} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b exp 000000", {hif.cmd_ready, sim_rst_n, sim_start, hif.res_valid, busy, done});
        end
        checks++; if (dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        tick();
        checks++; if (hif.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready: got %b exp 1", hif.cmd_ready);
        end
    endtask

    task automatic test_settle();
        bit ok; bit got; int last_c;
        send_cmd(1, 100);
        checks++; if ({busy, sim_rst_n, hif.cmd_ready, sim_start} !== 4'b1000) begin
            errors++; $display("FAIL settle_n1: got %b exp 1000", {busy, sim_rst_n, hif.cmd_ready, sim_start});
        end
        tick();
        checks++; if ({sim_rst_n, sim_start} !== 2'b00) begin
            errors++; $display("FAIL settle_n2: got %b exp 00", {sim_rst_n, sim_start});
        end
        tick();
        checks++; if ({sim_rst_n, sim_start} !== 2'b11) begin
            errors++; $display("FAIL settle_n3_start: got %b exp 11", {sim_rst_n, sim_start});
        end
        wait_start(ok);
        drive_run(16'h0, 0, 20, 200, got, last_c);
        checks++; if (last_c !== 23) begin
            errors++; $display("FAIL settle_cycle: got %0d exp 23", last_c);
        end
        checks++; if ({hif.res_run_idx, hif.res_iter, hif.res_timeout} !== {8'd0, 10'd23, 1'b0}) begin
            errors++; $display("FAIL settle_rec: got idx %0d iter %0d to %b exp idx 0 iter 23 to 0", hif.res_run_idx, hif.res_iter, hif.res_timeout);
        end
        checks++; if ({sim_rst_n, dbg_state} !== {1'b0, ST_REPORT}) begin
            errors++; $display("FAIL settle_report: got rst_n %b state %0d exp 0 %0d", sim_rst_n, dbg_state, ST_REPORT);
        end
        ack_result();
        checks++; if ({hif.res_valid, done, hif.cmd_ready, busy} !== 4'b0110) begin
            errors++; $display("FAIL settle_done: got %b exp 0110", {hif.res_valid, done, hif.cmd_ready, busy});
        end
        tick();
        checks++; if (done !== 1'b0) begin
            errors++; $display("FAIL settle_done_pulse: got %b exp 0", done);
        end
    endtask

    task automatic test_timeout();
        bit ok; bit got; int last_c;
        send_cmd(1, 50);
        wait_start(ok);
        checks++; if (ok !== 1'b1) begin
            errors++; $display("FAIL timeout_start: got %b exp 1", ok);
        end
        drive_run(16'h0, 0, 100000, 100, got, last_c);
        checks++; if ({got, hif.res_iter, hif.res_timeout} !== {1'b1, 10'd50, 1'b1}) begin
            errors++; $display("FAIL timeout_rec: got valid %b iter %0d to %b exp 1 50 1", got, hif.res_iter, hif.res_timeout);
        end
        ack_result();
        checks++; if (done !== 1'b1) begin
            errors++; $display("FAIL timeout_done: got %b exp 1", done);
        end
    endtask

    task automatic test_glitch();
        bit ok; bit got; int last_c;
        send_cmd(1, 100);
        wait_start(ok);
        // pattern 1,1,1,0,1,1,1,1 (bit 0 first), then held high
        drive_run(16'h00F7, 8, 0, 40, got, last_c);
        checks++; if (last_c !== 7) begin
            errors++; $display("FAIL glitch_cycle: got %0d exp 7", last_c);
        end
        checks++; if ({hif.res_iter, hif.res_timeout} !== {10'd7, 1'b0}) begin
            errors++; $display("FAIL glitch_rec: got iter %0d to %b exp 7 0", hif.res_iter, hif.res_timeout);
        end
        ack_result();
    endtask

    task automatic test_back_to_back();
        bit ok; bit got; int last_c; int n;
        result_t exp_rec;
        send_cmd(3, 100);
        wait_start(ok);
        for (int r = 0; r < 3; r++) begin
            drive_run(16'h0, 0, 5 + 2 * r, 100, got, last_c);
            exp_rec.run_idx = RUN_W'(r);
            exp_rec.iter    = ITER_W'(8 + 2 * r);
            exp_rec.timeout = 1'b0;
            checks++; if ({hif.res_run_idx, hif.res_iter, hif.res_timeout} !== exp_rec) begin
                errors++; $display("FAIL batch_rec%0d: got idx %0d iter %0d to %b exp idx %0d iter %0d", r, hif.res_run_idx, hif.res_iter, hif.res_timeout, r, 8 + 2 * r);
            end
            for (int s = 0; s < 5; s++) begin
                tick();
                checks++; if ({hif.res_valid, hif.res_run_idx, hif.res_iter, hif.res_timeout} !== {1'b1, exp_rec}) begin
                    errors++; $display("FAIL batch_stall%0d_%0d: got v %b idx %0d iter %0d exp v 1 idx %0d iter %0d", r, s, hif.res_valid, hif.res_run_idx, hif.res_iter, r, exp_rec.iter);
                end
            end
            ack_result();
            if (r < 2) begin
                checks++; if ({done, busy} !== 2'b01) begin
                    errors++; $display("FAIL batch_mid_done%0d: got %b exp 01", r, {done, busy});
                end
                n = 1;
                while (!sim_start && n < 10) begin
                    tick();
                    n++;
                end
                checks++; if (n !== 3) begin
                    errors++; $display("FAIL batch_restart%0d: got %0d exp 3", r, n);
                end
            end else begin
                checks++; if (done !== 1'b1) begin
                    errors++; $display("FAIL batch_done: got %b exp 1", done);
                end
            end
        end
    endtask

    task automatic test_edges();
        bit ok; bit got; int last_c; int starts;
        // zero-run batch
        send_cmd(0, 10);
        checks++; if ({done, busy, hif.cmd_ready} !== 3'b101) begin
            errors++; $display("FAIL zero_runs_done: got %b exp 101", {done, busy, hif.cmd_ready});
        end
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sim_start || done) starts++;
        end
        checks++; if (starts !== 0) begin
            errors++; $display("FAIL zero_runs_quiet: got %0d exp 0", starts);
        end
        // limit 0 behaves as 1023
        send_cmd(1, 0);
        wait_start(ok);
        drive_run(16'h0, 0, 100000, 1100, got, last_c);
        checks++; if ({last_c == 1023, hif.res_iter, hif.res_timeout} !== {1'b1, 10'd1023, 1'b1}) begin
            errors++; $display("FAIL limit0: got cycle %0d iter %0d to %b exp 1023 1023 1", last_c, hif.res_iter, hif.res_timeout);
        end
        ack_result();
        // settle completes on iter 30 with limit 30
        send_cmd(1, 30);
        wait_start(ok);
        drive_run(16'h0, 0, 27, 100, got, last_c);
        checks++; if ({hif.res_iter, hif.res_timeout} !== {10'd30, 1'b0}) begin
            errors++; $display("FAIL tie_settle_wins: got iter %0d to %b exp 30 0", hif.res_iter, hif.res_timeout);
        end
        ack_result();
    endtask

    task automatic test_reset_mid_run();
        bit ok; int seen;
        send_cmd(2, 100);
        wait_start(ok);
        tick();
        for (int c = 0; c < 3; c++) begin
            sim_iter   = ITER_W'(c);
            sim_steady = 1'b0;
            tick();
        end
        checks++; if (dbg_state !== ST_RUN) begin
            errors++; $display("FAIL midrst_in_run: got %0d exp %0d", dbg_state, ST_RUN);
        end
        rst = 1'b1;
        tick();
        checks++; if ({hif.cmd_ready, sim_rst_n, sim_start, hif.res_valid, busy, done} !== 6'b0) begin
            errors++; $display("FAIL midrst_ctrl: got %b exp 000000", {hif.cmd_ready, sim_rst_n, sim_start, hif.res_valid, busy, done});
        end
        checks++; if ({hif.res_run_idx, hif.res_iter, hif.res_timeout} !== 19'd0) begin
            errors++; $display("FAIL midrst_fields: got idx %0d iter %0d to %b exp 0", hif.res_run_idx, hif.res_iter, hif.res_timeout);
        end
        checks++; if (dbg_state !== ST_IDLE) begin
            errors++; $display("FAIL midrst_state: got %0d exp %0d", dbg_state, ST_IDLE);
        end
        seen = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (hif.res_valid || done) seen++;
        end
        rst = 1'b0;
        tick();
        checks++; if ({hif.cmd_ready, busy, done, seen != 0} !== 4'b1000) begin
            errors++; $display("FAIL midrst_release: got %b exp 1000", {hif.cmd_ready, busy, done, seen != 0});
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        hif.cmd_valid = 1'b0;
        hif.cmd_runs  = '0;
        hif.cmd_limit = '0;
        hif.res_ready = 1'b0;
        sim_steady    = 1'b0;
        sim_iter      = '0;

        test_reset();
        test_settle();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_edges();
        test_reset_mid_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
